// File: rtl/rib_timer_slave.sv
// rib_timer_slave: programmable 32-bit timer responding on interconnect slave
// port 2. Prescaled up-counter with compare/period match, one-shot and
// periodic modes, sticky write-1-to-clear pending flag and a level interrupt.
//
// Bus semantics: there is no valid/ready handshake. A write is a single-cycle
// transfer committed at the rising edge where wr_en_i=1; a read is purely
// combinational from addr_i, so every transfer completes with zero wait states
// and the block never applies backpressure.
module rib_timer_slave #(
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        wr_en_i,
  output logic [31:0] data_o,
  output logic        irq_o
);

  localparam logic [7:0] OFS_CTRL     = 8'h00;
  localparam logic [7:0] OFS_COUNT    = 8'h04;
  localparam logic [7:0] OFS_COMPARE  = 8'h08;
  localparam logic [7:0] OFS_STATUS   = 8'h0C;
  localparam logic [7:0] OFS_PRESCALE = 8'h10;

  // Architectural state
  logic [2:0]         ctrl;        // bit0 EN, bit1 ONESHOT, bit2 IRQ_EN
  logic [31:0]        count;
  logic [31:0]        compare;
  logic               pend;
  logic [PRESC_W-1:0] prescale;
  logic [PRESC_W-1:0] presc_cnt;

  // Only the low byte of the offset is decoded
  logic [23:0] unused_addr_hi;
  assign unused_addr_hi = addr_i[31:8];

  logic [7:0] ofs;
  assign ofs = addr_i[7:0];

  logic wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;
  assign wr_ctrl     = wr_en_i && (ofs == OFS_CTRL);
  assign wr_count    = wr_en_i && (ofs == OFS_COUNT);
  assign wr_compare  = wr_en_i && (ofs == OFS_COMPARE);
  assign wr_status   = wr_en_i && (ofs == OFS_STATUS);
  assign wr_prescale = wr_en_i && (ofs == OFS_PRESCALE);

  logic en, oneshot, irq_en;
  assign en      = ctrl[0];
  assign oneshot = ctrl[1];
  assign irq_en  = ctrl[2];

  // A tick fires when the prescaler reaches PRESCALE. A COUNT write suppresses
  // the match so a freshly loaded value is never compared in its load cycle.
  logic tick, match;
  assign tick  = en && (presc_cnt == prescale);
  assign match = tick && (count == compare) && !wr_count;

  // Prescaler: free-runs while enabled and wraps naturally at 2^PRESC_W, so a
  // PRESCALE lowered below the current presc_cnt costs one full wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      presc_cnt <= '0;
    else if (!en || wr_count || tick) presc_cnt <= '0;
    else                          presc_cnt <= presc_cnt + PRESC_W'(1);
  end

  // Counter: bus load wins over tick increment and match reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (wr_count) count <= data_i;
    else if (match)    count <= '0;
    else if (tick)     count <= count + 32'd1;
  end

  // Control: bus write wins over the one-shot auto-clear of EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     ctrl <= '0;
    else if (wr_ctrl)            ctrl <= data_i[2:0];
    else if (match && oneshot)   ctrl <= {ctrl[2:1], 1'b0};
  end

  // Pending flag: a match sets it even when a W1C lands in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         pend <= 1'b0;
    else if (match)                  pend <= 1'b1;
    else if (wr_status && data_i[0]) pend <= 1'b0;
  end

  // Plain configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare  <= '0;
      prescale <= '0;
    end else begin
      if (wr_compare)  compare  <= data_i;
      if (wr_prescale) prescale <= data_i[PRESC_W-1:0];
    end
  end

  // Zero-latency read mux; unmapped offsets read 0
  always_comb begin
    data_o = 32'd0;
    case (ofs)
      OFS_CTRL:     data_o = {29'd0, ctrl};
      OFS_COUNT:    data_o = count;
      OFS_COMPARE:  data_o = compare;
      OFS_STATUS:   data_o = {31'd0, pend};
      OFS_PRESCALE: data_o = 32'(prescale);
      default:      data_o = 32'd0;
    endcase
  end

  assign irq_o = pend && irq_en;

endmodule
